// File: rtl/mem_result_writer_pkg.sv
// Shared types and widths for the result-memory write sequencer.
package mem_result_writer_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_result_writer_sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mem_result_writer.sv
// Streams result words into the result memory at consecutive addresses,
// then pulses done so the memory dumps its contents.
module mem_result_writer
    import mem_result_writer_pkg::*;
#(
    parameter int SIZE      = 128,
    parameter int BASE_ADDR = 0,
    parameter int COUNT     = 128,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = $clog2(COUNT + 2);
    localparam logic [CNT_W-1:0]  COUNT_C = CNT_W'(COUNT);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(SIZE - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // RUN exits only once the write counter has caught up, so the last
    // mem_we cycle still belongs to RUN and FLUSH always sees mem_we low.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = (COUNT == 0) ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (wr_cnt == COUNT_C) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        pop      = 1'b0;
        if (state == ST_RUN) begin
            in_ready = !fifo_full && (acc_cnt < COUNT_C);
            pop      = !fifo_empty;
        end
    end

    assign push = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
            addr    <= '0;
        end else if (state == ST_IDLE && start) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
            addr    <= BASE_C;
        end else begin
            if (push) acc_cnt <= acc_cnt + 1'b1;
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
                addr   <= (addr == LAST_C) ? '0 : addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_we <= pop;
            if (pop) begin
                mem_waddr <= addr;
                mem_wdata <= fifo_rdata;
            end
            done <= (state_nx == ST_DONE);
            busy <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: doc/mem_result_writer.md
# mem_result_writer

Upstream write sequencer for the 128×32 result memory. Accepts a stream of 32-bit result words over a valid/ready handshake, buffers them in a small FIFO, and drives the memory's write port with consecutive addresses. After the programmed word count has been committed, it raises the one-cycle `done` pulse that makes the memory dump its contents to file.

## Interface
- `SIZE`, default 128: memory depth in words. Write addresses wrap modulo SIZE.
- `BASE_ADDR`, default 0: first write address for each run.
- `COUNT`, default 128: words written per run.
- `DEPTH`, default 4: FIFO depth. Must be a power of two and ≥2.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begins a run. Sampled only in IDLE.
- `in_valid` in 1: upstream word valid.
- `in_data` in 32: upstream result word.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `mem_we` out 1: to memory `we`.
- `mem_waddr` out 8: to memory `write_addr`.
- `mem_wdata` out 32: to memory `datai`.
- `done` out 1: to memory `done`. One-cycle pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`=1: address register ← BASE_ADDR, accept counter ← 0, write counter ← 0.
  - Next state is RUN, or FLUSH if COUNT==0.
- RUN:
  - `in_ready` = !fifo_full && (accept counter < COUNT).
  - A handshake (`in_valid`&&`in_ready`) pushes `in_data` and increments the accept counter.
  - Each cycle the FIFO is non-empty, pop one word and register:
    - `mem_we`=1
    - `mem_waddr`=address register
    - `mem_wdata`=popped word
  - Each pop increments the write counter and advances the address (wraps SIZE-1 → 0).
  - Cycles with no pop register `mem_we`=0. Address and data hold their last values.
  - Push and pop in the same cycle are both allowed. Full is judged before the pop (no pass-through when full).
  - When the write counter reaches COUNT, go to FLUSH.
- FLUSH: one cycle. `mem_we`=0. Guarantees the memory commits the last write before the dump. Next state is DONE.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE.
- Words offered after COUNT accepts see `in_ready`=0 and are not consumed.
- `start` while busy is ignored.
- Address arithmetic is 8-bit, (addr+1) mod SIZE. BASE_ADDR ≥ SIZE is illegal.

## Timing
- Reset values (async): state IDLE; FIFO empty; all counters 0; `mem_we`, `done`, `busy` = 0; `mem_waddr`=0; `mem_wdata`=0. `in_ready`=0, because it is derived from state.
- `rst` mid-run aborts immediately:
  - FIFO contents are discarded.
  - No `done` is issued.
  - The memory keeps any words already written.
- All memory-side outputs are registered. `in_ready` is combinational from registered state only, with no path from `in_valid`.
- Word latency: a word pushed at edge k into an empty FIFO is popped at edge k+1. `mem_we` is high during cycle k+1→k+2, and the memory commits it at edge k+2.
- Throughput: 1 word/cycle sustained.
- Last `mem_we` high cycle is followed by exactly 1 FLUSH cycle, then `done` high for 1 cycle.
- `done` and `mem_we` are never high in the same cycle.
- Run length with continuous input: COUNT + 4 cycles from `start` edge to `done` deassertion.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=0, RUN=1, FLUSH=2, DONE=3)
  - ADDR_W=8
  - DATA_W=32
- Sub-module `sync_fifo`:
  - parameters DEPTH, WIDTH
  - push/pop/full/empty
  - pointer-based, with an extra wrap bit for full/empty
  - async reset to empty
- Top level holds the FSM, counters, address generator and output registers.

## Test plan
- Reset, then `start` with continuous `in_valid`, `in_data`=i for i=0..127 → `mem_waddr` 0..127 with matching data, one write per cycle. `done` pulses once, 2 cycles after the last `mem_we`. Dumped memory[i]=i.
- BASE_ADDR=120, COUNT=16 → addresses 120..127 then 0..7; no write outside that set.
- Upstream stalls every other cycle, downstream pattern 0xA5A5_0000+i → no lost or duplicated words. `in_ready` drops only when the FIFO is full.
- COUNT=4 with `in_valid` held high → exactly 4 handshakes; `in_ready`=0 afterward; `done` pulses after 4 writes; `start` during the run is ignored.
- Assert `rst` after 10 writes → all outputs 0 in the same cycle (async). No `done` pulse. A new `start` restarts at BASE_ADDR.
- COUNT=0, `start` → no `mem_we`; `done` pulses 2 cycles after the `start` edge.
